// File: rtl/binary_matrix_pkg.sv
// Shared definitions for the binary (GF(2)) matrix datapath.
// gf2_dot works at the maximum supported width; callers zero-extend narrower operands.
package binary_matrix_pkg;

    localparam int MAX_N = 16;

    function automatic logic gf2_dot(
        input logic [MAX_N-1:0] row,
        input logic [MAX_N-1:0] vec
    );
        return ^(row & vec);
    endfunction

endpackage

// File: rtl/gf2_row_dot.sv
// One output bit of u = A * v over GF(2): AND the row with the vector, then XOR-reduce.
module gf2_row_dot
    import binary_matrix_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] i_row,
    input  logic [N-1:0] i_vec,
    output logic         o_bit
);

    logic [MAX_N-1:0] w_row_ext;
    logic [MAX_N-1:0] w_vec_ext;

    // Zero padding above bit N-1 leaves the mod-2 sum unchanged.
    always_comb begin
        w_row_ext = {MAX_N{1'b0}};
        w_vec_ext = {MAX_N{1'b0}};
        w_row_ext[N-1:0] = i_row;
        w_vec_ext[N-1:0] = i_vec;
        o_bit = gf2_dot(w_row_ext, w_vec_ext);
    end

endmodule

// File: rtl/binary_matrix_vec_mul.sv
// GF(2) matrix-vector multiply u = A * v with one-cycle registered result.
// A is column-major flat: element (row i, column j) sits at A[j*N + i].
module binary_matrix_vec_mul
    import binary_matrix_pkg::*;
#(
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [N*N-1:0] A,
    input  logic [N-1:0]   v,
    output logic [N-1:0]   u,
    output logic           out_valid
);

    logic [N-1:0] w_u_next;
    logic [N-1:0] r_u;
    logic         r_out_valid;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        logic [N-1:0] w_row;

        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign w_row[gj] = A[gj*N + gi];
        end

        gf2_row_dot #(.N(N)) u_row_dot (
            .i_row (w_row),
            .i_vec (v),
            .o_bit (w_u_next[gi])
        );
    end

    // Result register: captures on in_valid, holds otherwise; out_valid pulses per result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_u         <= {N{1'b0}};
            r_out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                r_u <= w_u_next;
            end else begin
                r_u <= r_u;
            end
            r_out_valid <= in_valid;
        end
    end

    assign u         = r_u;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_binary_matrix_vec_mul.sv
// Self-checking bench for binary_matrix_vec_mul (N=3) against an arithmetic GF(2) model.
module tb_binary_matrix_vec_mul;

    localparam int N = 3;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [N*N-1:0] A;
    logic [N-1:0]   v;
    logic [N-1:0]   u;
    logic           out_valid;

    int checks   = 0;
    int failures = 0;

    binary_matrix_vec_mul #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .v         (v),
        .u         (u),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count the 1-products in each row and keep the count mod 2.
    function automatic logic [N-1:0] ref_mul(input logic [N*N-1:0] a, input logic [N-1:0] vv);
        logic [N-1:0] r;
        int           s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            s = 0;
            for (int j = 0; j < N; j++) begin
                if (a[j*N + i] == 1'b1 && vv[j] == 1'b1) s = s + 1;
            end
            r[i] = (s % 2 == 1);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input just after an edge, then sample just after the capturing edge.
    task automatic step(input logic vld, input logic [N*N-1:0] a, input logic [N-1:0] vv);
        in_valid = vld;
        A        = a;
        v        = vv;
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] exp_u;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        A        = 9'($urandom);
        v        = 3'($urandom);

        // Reset held with valid traffic: nothing is captured.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            A = 9'($urandom);
            v = 3'($urandom) | 3'b001;
            chk("reset_u", 32'(u), 32'd0);
            chk("reset_valid", 32'(out_valid), 32'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_u", 32'(u), 32'd0);
        chk("post_reset_valid", 32'(out_valid), 32'd0);

        // Identity.
        step(1'b1, 9'b100_010_001, 3'b101);
        chk("ident_u", 32'(u), 32'd5);
        chk("ident_valid", 32'(out_valid), 32'd1);
        step(1'b0, 9'b111_111_111, 3'b111);
        chk("ident_hold_u", 32'(u), 32'd5);
        chk("ident_hold_valid", 32'(out_valid), 32'd0);

        // Parity with all-ones A.
        step(1'b1, 9'b111_111_111, 3'b111);
        chk("parity_all_ones", 32'(u), 32'd7);
        step(1'b1, 9'b111_111_111, 3'b011);
        chk("parity_even", 32'(u), 32'd0);

        // Indexing: only A_2_0 (bit 2) set.
        step(1'b1, 9'b000_000_100, 3'b001);
        chk("index_col0", 32'(u), 32'd4);
        step(1'b1, 9'b000_000_100, 3'b010);
        chk("index_col1", 32'(u), 32'd0);

        // Zero operands.
        step(1'b1, 9'b000_000_000, 3'b111);
        chk("zero_A", 32'(u), 32'd0);
        step(1'b1, 9'b111_111_111, 3'b000);
        chk("zero_v", 32'(u), 32'd0);

        // Exhaustive back-to-back sweep.
        for (int k = 0; k < 4096; k++) begin
            logic [11:0] kk;
            kk = 12'(k);
            step(1'b1, kk[8:0], kk[11:9]);
            chk("sweep_u", 32'(u), 32'(ref_mul(kk[8:0], kk[11:9])));
            chk("sweep_valid", 32'(out_valid), 32'd1);
        end

        // Random traffic with gaps; held value tracked by the model.
        exp_u = u;
        for (int k = 0; k < 300; k++) begin
            logic          vld;
            logic [8:0]    ra;
            logic [2:0]    rv;
            vld = 1'($urandom);
            ra  = 9'($urandom);
            rv  = 3'($urandom);
            if (vld) exp_u = ref_mul(ra, rv);
            step(vld, ra, rv);
            chk("rand_u", 32'(u), 32'(exp_u));
            chk("rand_valid", 32'(out_valid), 32'(vld));
        end

        // Asynchronous reset mid-burst, between edges.
        step(1'b1, 9'b111_111_111, 3'b111);
        chk("burst_u", 32'(u), 32'd7);
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_u", 32'(u), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("async_rst_held_u", 32'(u), 32'd0);
        chk("async_rst_held_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        step(1'b1, 9'b100_010_001, 3'b110);
        chk("after_rst_u", 32'(u), 32'd6);
        chk("after_rst_valid", 32'(out_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
